// File: rtl/branch_pht_updater_if.sv
// Decode lookup, Execute update and statistics bundle of the branch pattern-history table.
interface branch_pht_updater_if #(
    parameter int unsigned IDX_W = 10,
    parameter int unsigned CNT_W = 16
);
    logic [IDX_W-1:0] rd_idx;
    logic             prediction;
    logic             upd_en;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_pred;
    logic             ready;
    logic             mispredict;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output rd_idx, upd_en, upd_idx, upd_taken, upd_pred,
        input  prediction, ready, mispredict, branch_count, mispredict_count
    );

    modport slave (
        input  rd_idx, upd_en, upd_idx, upd_taken, upd_pred,
        output prediction, ready, mispredict, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_pht_updater.sv
// Two-bit saturating pattern-history table: init sweep after reset, two-stage
// read-modify-write update with lookup bypass, and misprediction statistics.
module branch_pht_updater #(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned CNT_W    = 16,
    parameter logic [1:0]  INIT_VAL = 2'b01
) (
    input logic clk,
    input logic reset,
    branch_pht_updater_if.slave bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic {INIT, RUN} stateT;

    stateT            stateQ, stateD;
    logic [IDX_W-1:0] ptrQ, ptrD;
    logic [1:0]       pht [DEPTH];

    logic             u1Valid;
    logic [IDX_W-1:0] idxR;
    logic             takenR;
    logic             predR;

    logic             mispredictQ;
    logic [CNT_W-1:0] branchCountQ;
    logic [CNT_W-1:0] mispredictCountQ;

    logic             accept;
    logic             wrEn;
    logic [IDX_W-1:0] wrIdx;
    logic [1:0]       wrVal;
    logic [1:0]       curVal;
    logic [1:0]       nextVal;
    logic             predictionC;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= INIT;
            ptrQ   <= '0;
        end else begin
            stateQ <= stateD;
            ptrQ   <= ptrD;
        end
    end

    // Sweep writes INIT_VAL in INIT; in RUN the single write port belongs to U2.
    always_comb begin
        stateD  = stateQ;
        ptrD    = ptrQ;
        accept  = 1'b0;
        wrEn    = 1'b0;
        wrIdx   = ptrQ;
        wrVal   = INIT_VAL;
        curVal  = pht[idxR];
        nextVal = curVal;
        if (takenR) begin
            if (curVal != 2'b11) nextVal = curVal + 2'd1;
        end else begin
            if (curVal != 2'b00) nextVal = curVal - 2'd1;
        end
        case (stateQ)
            INIT: begin
                wrEn = 1'b1;
                ptrD = ptrQ + IDX_W'(1);
                if (ptrQ == '1) stateD = RUN;
            end
            RUN: begin
                accept = bus.upd_en;
                if (u1Valid) begin
                    wrEn  = 1'b1;
                    wrIdx = idxR;
                    wrVal = nextVal;
                end
            end
            default: stateD = INIT;
        endcase
    end

    // Table has no reset of its own; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (wrEn && !reset) pht[wrIdx] <= wrVal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            u1Valid          <= 1'b0;
            idxR             <= '0;
            takenR           <= 1'b0;
            predR            <= 1'b0;
            mispredictQ      <= 1'b0;
            branchCountQ     <= '0;
            mispredictCountQ <= '0;
        end else begin
            u1Valid     <= accept;
            idxR        <= bus.upd_idx;
            takenR      <= bus.upd_taken;
            predR       <= bus.upd_pred;
            // Pulse lines up with the U2 cycle of the mispredicted branch.
            mispredictQ <= accept && (bus.upd_taken != bus.upd_pred);
            if (u1Valid) begin
                if (branchCountQ != '1) branchCountQ <= branchCountQ + CNT_W'(1);
                if ((takenR != predR) && (mispredictCountQ != '1))
                    mispredictCountQ <= mispredictCountQ + CNT_W'(1);
            end
        end
    end

    // Lookup forwards the in-flight U2 result so Decode never sees a stale entry.
    always_comb begin
        predictionC = 1'b0;
        if (stateQ == RUN) begin
            if (u1Valid && (idxR == bus.rd_idx)) predictionC = nextVal[1];
            else                                 predictionC = pht[bus.rd_idx][1];
        end
    end

    assign bus.prediction       = predictionC;
    assign bus.ready            = (stateQ == RUN);
    assign bus.mispredict       = mispredictQ;
    assign bus.branch_count     = branchCountQ;
    assign bus.mispredict_count = mispredictCountQ;
endmodule

// File: tb/tb_branch_pht_updater.sv
// Directed plus randomized bench for branch_pht_updater with a cycle-level reference model.
module tb_branch_pht_updater;
    localparam int IDX_W = 4;
    localparam int CNT_W = 4;
    localparam int DEPTH = 16;
    localparam int CMAX  = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_pht_updater_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    branch_pht_updater #(.IDX_W(IDX_W), .CNT_W(CNT_W), .INIT_VAL(2'b01)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: counter values as plain integers, one pending resolved branch.
    int mTab [DEPTH];
    int mCnt;
    bit mPendV, mPendT, mPendP;
    int mPendIdx;
    int mBr, mMis;
    bit modelOk = 1'b0;

    logic       obsPred, obsMis, obsRdy;
    logic [3:0] obsBr, obsMc;

    function automatic int satStep(input int v, input bit taken);
        if (taken) return (v < 3) ? v + 1 : 3;
        return (v > 0) ? v - 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model at the rising edge.
    task automatic tick(input bit rst, input bit en, input int idx, input bit tk, input bit pr, input int rd);
        bit expRdy, expPred, expMis;
        reset         = rst;
        bus.upd_en    = en;
        bus.upd_idx   = 4'(idx);
        bus.upd_taken = tk;
        bus.upd_pred  = pr;
        bus.rd_idx    = 4'(rd);
        @(negedge clk);
        obsPred = bus.prediction;
        obsMis  = bus.mispredict;
        obsRdy  = bus.ready;
        obsBr   = bus.branch_count;
        obsMc   = bus.mispredict_count;
        if (modelOk) begin
            expRdy = (mCnt >= DEPTH);
            if (!expRdy)                          expPred = 1'b0;
            else if (mPendV && mPendIdx == rd)    expPred = (satStep(mTab[rd], mPendT) >= 2);
            else                                  expPred = (mTab[rd] >= 2);
            expMis = mPendV && (mPendT != mPendP);
            chk("ready", 32'(obsRdy), 32'(expRdy));
            chk("prediction", 32'(obsPred), 32'(expPred));
            chk("mispredict", 32'(obsMis), 32'(expMis));
            chk("branch_count", 32'(obsBr), 32'(mBr));
            chk("mispredict_count", 32'(obsMc), 32'(mMis));
        end
        @(posedge clk);
        if (rst) begin
            foreach (mTab[i]) mTab[i] = 1;
            mCnt = 0; mPendV = 0; mBr = 0; mMis = 0;
            modelOk = 1'b1;
        end else begin
            if (mPendV) begin
                mTab[mPendIdx] = satStep(mTab[mPendIdx], mPendT);
                if (mBr < CMAX) mBr++;
                if (mPendT != mPendP && mMis < CMAX) mMis++;
            end
            mPendV   = (mCnt >= DEPTH) && en;
            mPendIdx = idx; mPendT = tk; mPendP = pr;
            if (mCnt < DEPTH) mCnt++;
        end
        #1;
    endtask

    task automatic sweep();
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("sweep_ready", 32'(obsRdy), 32'd1);
    endtask

    initial begin
        int lowCnt, predOnes, pulses;
        reset = 1'b1;
        bus.upd_en = 0; bus.upd_idx = 0; bus.upd_taken = 0; bus.upd_pred = 0; bus.rd_idx = 0;

        // Init sweep: ready low exactly 16 cycles, predictions 0, updates dropped.
        tick(1, 0, 0, 0, 0, 0);
        lowCnt = 0; predOnes = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, 1, i, 1, 0, i);
            if (obsRdy === 1'b0) lowCnt++;
            if (obsPred !== 1'b0) predOnes++;
        end
        tick(0, 0, 0, 0, 0, 0);
        chk("init_low_cycles", 32'(lowCnt), 32'd16);
        chk("init_pred_zero", 32'(predOnes), 32'd0);
        chk("init_ready_after", 32'(obsRdy), 32'd1);
        chk("init_updates_dropped", 32'(obsBr), 32'd0);

        // Saturation at idx 5.
        for (int i = 0; i < 3; i++) tick(0, 1, 5, 1, 0, 5);
        tick(0, 0, 0, 0, 0, 5);
        tick(0, 0, 0, 0, 0, 5);
        chk("sat_taken_pred", 32'(obsPred), 32'd1);
        tick(0, 1, 5, 0, 1, 5);
        tick(0, 0, 0, 0, 0, 5);
        tick(0, 0, 0, 0, 0, 5);
        chk("sat_one_nt_pred", 32'(obsPred), 32'd1);
        for (int i = 0; i < 3; i++) tick(0, 1, 5, 0, 1, 5);
        tick(0, 0, 0, 0, 0, 5);
        tick(0, 0, 0, 0, 0, 5);
        chk("sat_nt_pred", 32'(obsPred), 32'd0);

        // Bypass at idx 3 (counter 01).
        tick(0, 1, 3, 1, 0, 3);
        chk("bypass_cycle_t", 32'(obsPred), 32'd0);
        tick(0, 0, 0, 0, 0, 3);
        chk("bypass_cycle_t1", 32'(obsPred), 32'd1);

        // Back-to-back taken at idx 7 from 00, then one not-taken must leave 10.
        tick(0, 1, 7, 0, 0, 7);
        tick(0, 1, 7, 0, 0, 7);
        tick(0, 0, 0, 0, 0, 7);
        for (int i = 0; i < 3; i++) tick(0, 1, 7, 1, 0, 7);
        tick(0, 1, 7, 0, 1, 7);
        tick(0, 0, 0, 0, 0, 7);
        tick(0, 0, 0, 0, 0, 7);
        chk("b2b_no_lost_update", 32'(obsPred), 32'd1);

        // Statistics: 10 updates with 4 mispredicts, then saturation of branch_count.
        sweep();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            bit tk;
            tk = 1'($urandom_range(0, 1));
            tick(0, 1, i % 8, tk, (i == 1 || i == 4 || i == 6 || i == 9) ? !tk : tk, 0);
            if (obsMis === 1'b1) pulses++;
        end
        tick(0, 0, 0, 0, 0, 0);
        if (obsMis === 1'b1) pulses++;
        tick(0, 0, 0, 0, 0, 0);
        if (obsMis === 1'b1) pulses++;
        chk("stat_branch_count", 32'(obsBr), 32'd10);
        chk("stat_mispredict_count", 32'(obsMc), 32'd4);
        chk("stat_pulses", 32'(pulses), 32'd4);
        for (int i = 0; i < 10; i++) tick(0, 1, i % 8, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("stat_branch_saturated", 32'(obsBr), 32'd15);

        // Reset in the cycle after a mispredicted update at idx 9.
        tick(0, 1, 9, 1, 0, 9);
        tick(1, 0, 0, 0, 0, 9);
        chk("midrst_pulse_seen", 32'(obsMis), 32'd1);
        tick(0, 0, 0, 0, 0, 9);
        chk("midrst_mispredict", 32'(obsMis), 32'd0);
        chk("midrst_branch_count", 32'(obsBr), 32'd0);
        chk("midrst_mispredict_count", 32'(obsMc), 32'd0);
        chk("midrst_ready", 32'(obsRdy), 32'd0);
        for (int i = 0; i < DEPTH; i++) tick(0, 0, 0, 0, 0, 9);
        chk("midrst_ready_after", 32'(obsRdy), 32'd1);
        chk("midrst_idx9_pred", 32'(obsPred), 32'd0);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
